// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, load-op codes and
// response-FSM state codes.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 75;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_TO_ID_BUS_WD = 39;

  typedef enum logic [2:0] {
    LOP_NONE = 3'd0,
    LOP_LB   = 3'd1,
    LOP_LBU  = 3'd2,
    LOP_LH   = 3'd3,
    LOP_LHU  = 3'd4,
    LOP_LW   = 3'd5
  } load_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HAVE = 2'd2
  } ms_state_e;

  // Codes 110/111 are reserved and behave like a non-load.
  function automatic logic is_load_op(input logic [2:0] op);
    return (op >= LOP_LB) && (op <= LOP_LW);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half/word out of a 32-bit load response and
// sign- or zero-extends it. Purely combinational.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  i_load_op,
  input  logic [1:0]  i_addr_low,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection: bytes by full addr_low, halves by addr_low[1] only
  // (misaligned halves are not trapped here).
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_low)
      2'b00:   w_byte = i_raw[7:0];
      2'b01:   w_byte = i_raw[15:8];
      2'b10:   w_byte = i_raw[23:16];
      default: w_byte = i_raw[31:24];
    endcase
    w_half = i_addr_low[1] ? i_raw[31:16] : i_raw[15:0];
  end

  // Extension according to the load kind.
  always_comb begin
    o_data = i_raw;
    case (i_load_op)
      LOP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      LOP_LBU: o_data = {24'h000000, w_byte};
      LOP_LH:  o_data = {{16{w_half[15]}}, w_half};
      LOP_LHU: o_data = {16'h0000, w_half};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the in-order pipeline: holds one instruction from EX, waits
// for the data-SRAM response on loads, and hands the result to WB through a
// valid/allowin handshake. Also publishes a forwarding/stall bus to ID.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_TO_ID_BUS_WD-1:0] ms_to_id_bus
);

  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
  ms_state_e                  r_state;
  logic [31:0]                r_rdata_buf;

  logic [2:0]  w_load_op;
  logic [1:0]  w_addr_low;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;
  logic        w_is_load;
  logic        w_in_is_load;
  logic        w_resp_now;
  logic        w_ready_go;
  logic        w_capture;
  logic [31:0] w_raw;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;
  logic        w_fwd_en;
  logic        w_fwd_blocked;

  assign {w_load_op, w_addr_low, w_gr_we, w_dest, w_alu_result, w_pc} = r_es_bus;

  assign w_is_load    = is_load_op(w_load_op);
  assign w_in_is_load = is_load_op(es_to_ms_bus[74:72]);

  // A response only counts for a held instruction that is still waiting;
  // anything else on data_ok is stray and dropped.
  assign w_resp_now = r_ms_valid && (r_state == ST_WAIT) && data_sram_data_ok;

  // Same-cycle response is used straight from the SRAM port, so a load
  // whose data_ok arrives in its first MEM cycle costs no bubble.
  assign w_ready_go = !w_is_load || (r_state == ST_HAVE) || w_resp_now;

  assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_ms_valid && w_ready_go;
  assign w_capture      = es_to_ms_valid && ms_allowin;

  // Valid bit: refreshed from EX whenever the stage can accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      r_ms_valid <= es_to_ms_valid;
    end
  end

  // Instruction bus register: loads only on a real capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_es_bus <= '0;
    end else if (w_capture) begin
      r_es_bus <= es_to_ms_bus;
    end
  end

  // Response FSM; a capture always restarts it for the new instruction, so
  // a data_ok coinciding with a capture can only complete the departing one.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else if (w_capture) begin
      r_state <= w_in_is_load ? ST_WAIT : ST_IDLE;
    end else if (ms_allowin) begin
      r_state <= ST_IDLE;
    end else if (w_resp_now) begin
      r_state <= ST_HAVE;
    end
  end

  // Response buffer: keeps load data while WB is stalling the stage.
  always_ff @(posedge clk) begin
    if (w_resp_now) begin
      r_rdata_buf <= data_sram_rdata;
    end
  end

  assign w_raw = w_resp_now ? data_sram_rdata : r_rdata_buf;

  mem_stage_load_align u_load_align (
    .i_load_op  (w_load_op),
    .i_addr_low (w_addr_low),
    .i_raw      (w_raw),
    .o_data     (w_load_data)
  );

  assign w_final_result = w_is_load ? w_load_data : w_alu_result;

  assign w_fwd_en      = r_ms_valid && w_gr_we && (w_dest != 5'd0);
  assign w_fwd_blocked = w_fwd_en && w_is_load && !w_ready_go;

  assign ms_to_ws_bus = {w_gr_we, w_dest, w_final_result, w_pc};
  assign ms_to_id_bus = {w_fwd_en, w_fwd_blocked, w_dest, w_final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single instructions plus
// hand-written multi-cycle sequences (stalls, reset mid-wait, streaming).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [38:0] ms_to_id_bus;

  logic        o_gr_we;
  logic [4:0]  o_dest;
  logic [31:0] o_result;
  logic [31:0] o_pc;
  logic        f_en;
  logic        f_blk;
  logic [4:0]  f_dest;
  logic [31:0] f_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_id_bus      (ms_to_id_bus)
  );

  assign {o_gr_we, o_dest, o_result, o_pc} = ms_to_ws_bus;
  assign {f_en, f_blk, f_dest, f_data}     = ms_to_id_bus;

  typedef struct {
    logic [2:0]  lop;
    logic [1:0]  al;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] lop, input logic [1:0] al,
                       input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc);
    es_to_ms_valid = v;
    es_to_ms_bus   = {lop, al, 1'b1, dest, alu, pc};
  endtask

  initial begin
    // {load_op, addr_low, dest, alu_result, rdata, expected final_result}
    vecs[0]  = '{3'd0, 2'd0, 5'd5,  32'h1234_5678, 32'h80FF_7F01, 32'h1234_5678};
    vecs[1]  = '{3'd1, 2'd0, 5'd6,  32'h0000_1000, 32'h80FF_7F01, 32'h0000_0001};
    vecs[2]  = '{3'd1, 2'd1, 5'd6,  32'h0000_1001, 32'h80FF_7F01, 32'h0000_007F};
    vecs[3]  = '{3'd1, 2'd2, 5'd6,  32'h0000_1002, 32'h80FF_7F01, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd1, 2'd3, 5'd6,  32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_FF80};
    vecs[5]  = '{3'd2, 2'd2, 5'd7,  32'h0000_1002, 32'h80FF_7F01, 32'h0000_00FF};
    vecs[6]  = '{3'd2, 2'd3, 5'd7,  32'h0000_1003, 32'h80FF_7F01, 32'h0000_0080};
    vecs[7]  = '{3'd3, 2'd0, 5'd8,  32'h0000_2000, 32'h8001_F234, 32'hFFFF_F234};
    vecs[8]  = '{3'd3, 2'd3, 5'd8,  32'h0000_2003, 32'h8001_F234, 32'hFFFF_8001};
    vecs[9]  = '{3'd4, 2'd2, 5'd9,  32'h0000_2002, 32'h8001_1234, 32'h0000_8001};
    vecs[10] = '{3'd4, 2'd1, 5'd9,  32'h0000_2001, 32'h8001_F234, 32'h0000_F234};
    vecs[11] = '{3'd5, 2'd0, 5'd10, 32'h0000_3000, 32'h8001_F234, 32'h8001_F234};
    vecs[12] = '{3'd6, 2'd0, 5'd11, 32'hCAFE_F00D, 32'h8001_F234, 32'hCAFE_F00D};
    vecs[13] = '{3'd7, 2'd1, 5'd0,  32'h0BAD_CAFE, 32'h8001_F234, 32'h0BAD_CAFE};

    resetn            = 1'b0;
    ws_allowin        = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_5555;
    drive(1'b1, 3'd5, 2'd0, 5'd3, 32'h0, 32'hBFC0_0000);

    // Reset state, with inputs deliberately active.
    tick();
    tick();
    @(negedge clk);
    check("rst_valid",   {31'd0, ms_to_ws_valid}, 32'd0);
    check("rst_allowin", {31'd0, ms_allowin},     32'd1);
    check("rst_fwd_en",  {31'd0, f_en},           32'd0);
    check("rst_fwd_blk", {31'd0, f_blk},          32'd0);
    tick();
    resetn            = 1'b1;
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b0;
    tick();

    // Table: capture, then present the response (always, even for non-loads).
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].lop, vecs[i].al, vecs[i].dest, vecs[i].alu, 32'h0000_1000 + i * 4);
      tick();
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = vecs[i].rdata;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i),   {31'd0, ms_to_ws_valid}, 32'd1);
      check($sformatf("vec%0d_result", i),  o_result, vecs[i].exp);
      check($sformatf("vec%0d_pc", i),      o_pc, 32'h0000_1000 + i * 4);
      check($sformatf("vec%0d_allowin", i), {31'd0, ms_allowin}, 32'd1);
      check($sformatf("vec%0d_fwd_en", i),  {31'd0, f_en}, {31'd0, vecs[i].dest != 5'd0});
      check($sformatf("vec%0d_fwd_blk", i), {31'd0, f_blk}, 32'd0);
      check($sformatf("vec%0d_fwd_data", i), f_data, vecs[i].exp);
      tick();
      data_sram_data_ok = 1'b0;
    end
    @(negedge clk);
    check("tbl_drain_valid", {31'd0, ms_to_ws_valid}, 32'd0);

    // LB addr_low=11, response three cycles after capture.
    tick();
    drive(1'b1, 3'd1, 2'd3, 5'd7, 32'h0000_0103, 32'h0000_0200);
    tick();
    es_to_ms_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("lb_wait%0d_valid", c),   {31'd0, ms_to_ws_valid}, 32'd0);
      check($sformatf("lb_wait%0d_blk", c),     {31'd0, f_blk}, 32'd1);
      check($sformatf("lb_wait%0d_allowin", c), {31'd0, ms_allowin}, 32'd0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_0000;
    @(negedge clk);
    check("lb_done_valid",  {31'd0, ms_to_ws_valid}, 32'd1);
    check("lb_done_result", o_result, 32'hFFFF_FF80);
    check("lb_done_blk",    {31'd0, f_blk}, 32'd0);
    check("lb_done_dest",   {27'd0, o_dest}, 32'd7);
    check("lb_done_gr_we",  {31'd0, o_gr_we}, 32'd1);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    @(negedge clk);
    check("lb_after_valid",  {31'd0, ms_to_ws_valid}, 32'd0);
    check("lb_after_fwd_en", {31'd0, f_en}, 32'd0);
    tick();
    data_sram_data_ok = 1'b0;

    // LW whose response lands while WB stalls for four cycles.
    drive(1'b1, 3'd5, 2'd0, 5'd12, 32'h0000_4000, 32'h0000_0300);
    tick();
    es_to_ms_valid    = 1'b0;
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    check("lw_stall0_valid",   {31'd0, ms_to_ws_valid}, 32'd1);
    check("lw_stall0_allowin", {31'd0, ms_allowin}, 32'd0);
    check("lw_stall0_result",  o_result, 32'hDEAD_BEEF);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h1111_1111;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("lw_stall%0d_result", c),  o_result, 32'hDEAD_BEEF);
      check($sformatf("lw_stall%0d_allowin", c), {31'd0, ms_allowin}, 32'd0);
      check($sformatf("lw_stall%0d_valid", c),   {31'd0, ms_to_ws_valid}, 32'd1);
      if (c == 2) data_sram_data_ok = 1'b1;
      tick();
      data_sram_data_ok = 1'b0;
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    check("lw_release_result",  o_result, 32'hDEAD_BEEF);
    check("lw_release_allowin", {31'd0, ms_allowin}, 32'd1);
    check("lw_release_valid",   {31'd0, ms_to_ws_valid}, 32'd1);
    tick();
    @(negedge clk);
    check("lw_gone_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    tick();

    // Reset pulse mid-WAIT, then a stray response.
    drive(1'b1, 3'd5, 2'd0, 5'd13, 32'h0000_5000, 32'h0000_0400);
    tick();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("rstw_pre_blk", {31'd0, f_blk}, 32'd1);
    tick();
    resetn = 1'b0;
    tick();
    resetn            = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h7777_7777;
    @(negedge clk);
    check("rstw_stray_valid",   {31'd0, ms_to_ws_valid}, 32'd0);
    check("rstw_stray_fwd_en",  {31'd0, f_en}, 32'd0);
    check("rstw_stray_allowin", {31'd0, ms_allowin}, 32'd1);
    tick();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    check("rstw_later_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    tick();

    // Four back-to-back LWs with a response every cycle.
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drive(1'b1, 3'd5, 2'd0, 5'd14, 32'h0000_6000, 32'h0000_0500 + c * 4);
      else       es_to_ms_valid = 1'b0;
      data_sram_data_ok = (c > 0);
      data_sram_rdata   = 32'hA000_0000 + c - 1;
      @(negedge clk);
      if (c > 0) begin
        check($sformatf("b2b%0d_valid", c),   {31'd0, ms_to_ws_valid}, 32'd1);
        check($sformatf("b2b%0d_pc", c),      o_pc, 32'h0000_0500 + (c - 1) * 4);
        check($sformatf("b2b%0d_result", c),  o_result, 32'hA000_0000 + c - 1);
        check($sformatf("b2b%0d_allowin", c), {31'd0, ms_allowin}, 32'd1);
      end
      tick();
    end
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    check("b2b_drain_valid", {31'd0, ms_to_ws_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage in-order pipeline; the transmitting end of the MEM->WB valid/allowin handshake.
- Accepts instructions from EX.
- For loads, waits for the data-SRAM response and extracts/extends the addressed byte, half or word.
- Drives the 70-bit MEM->WB bus ({gr_we, dest, final_result, pc}) and a forwarding/stall bus to ID.

Parameters:
- None. All widths come from the shared header: ES_TO_MS_BUS_WD=75, MS_TO_WS_BUS_WD=70, MS_TO_ID_BUS_WD=39.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- ws_allowin  in  1  WB can accept this cycle
- ms_allowin  out  1  MEM can accept from EX
- es_to_ms_valid  in  1  EX presents valid instruction
- es_to_ms_bus  in  75  {load_op[74:72], addr_low[71:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- ms_to_ws_valid  out  1  valid toward WB
- ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- data_sram_data_ok  in  1  one-cycle pulse, read/write response returned
- data_sram_rdata  in  32  load data, valid with data_ok
- ms_to_id_bus  out  39  {fwd_en[38], fwd_blocked[37], dest[36:32], fwd_data[31:0]}

Behaviour:
- load_op encoding: 000 non-load, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; 110/111 are treated as 000. Stores arrive with load_op=000 and gr_we=0, and do not wait for data_ok.
- Input register:
  - ms_valid resets to 0. When ms_allowin=1: ms_valid <= es_to_ms_valid.
  - The bus register loads on es_to_ms_valid && ms_allowin; otherwise it holds.
- Response FSM (per instruction), encoded in 2 bits:
  - WAIT (entered on capture of a load) -> HAVE on data_ok.
  - HAVE -> IDLE when the instruction leaves (ms_valid && ms_ready_go && ws_allowin).
  - Non-load captures go directly to IDLE.
- rdata buffer: on data_ok in WAIT, latch data_sram_rdata into rdata_buf. The buffer holds across WB stalls (ws_allowin=0).
- Ready-go: ms_ready_go = !is_load || state==HAVE || (state==WAIT && data_sram_data_ok). A same-cycle data_ok is used directly from the input (zero-bubble).
- Handshake:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - Latency: non-load = 1 cycle in MEM. Load = max(1, cycles to data_ok).
- Extraction: raw = data_ok-this-cycle ? data_sram_rdata : rdata_buf.
  - Byte select by addr_low: 00->[7:0], 01->[15:8], 10->[23:16], 11->[31:24].
  - Half select by addr_low[1]: 0->[15:0], 1->[31:16]; addr_low[0] is ignored (no alignment exception).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW = raw.
  - final_result = is_load ? extracted : alu_result.
- Forwarding bus:
  - fwd_en = ms_valid && gr_we && dest!=0.
  - fwd_blocked = fwd_en && is_load && !ms_ready_go; ID must stall on a match.
  - fwd_data = final_result.
- Outputs under reset: ms_valid=0, state=IDLE, ms_to_ws_valid=0, fwd_en=0, fwd_blocked=0, ms_allowin=1. Bus contents are don't-care but deterministic: reset the bus register to 0.
- Boundary conditions:
  - data_ok while ms_valid=0 or state!=WAIT is ignored.
  - data_ok in the same cycle a new instruction is captured belongs to the departing instruction, never the new one.
  - Reset asserted mid-WAIT returns to IDLE; a later stray data_ok is ignored.
  - Back-to-back loads with data_ok every cycle sustain 1 instruction/cycle.

Decomposition:
- Shared header (mycpu.h): bus-width macros; load_op codes (LOP_NONE/LB/LBU/LH/LHU/LW); FSM state codes.
- Sub-module load_align (combinational): inputs load_op, addr_low, raw[31:0]; output data[31:0]. It is reused later by unaligned-load extensions.

Test Plan:
- ADD, alu_result=0x1234_5678, dest=5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x1234_5678; fwd_en=1, fwd_blocked=0.
- LB addr_low=11, data_ok 3 cycles later with rdata=0x80FF_0000 -> fwd_blocked=1 for 2 cycles; then final_result=0xFFFF_FF80, valid for exactly 1 cycle.
- LHU addr_low=10, rdata=0x8001_1234, data_ok same cycle as capture+1 -> final_result=0x0000_8001, no bubble.
- LW, data_ok arrives while ws_allowin=0 for 4 cycles, rdata=0xDEAD_BEEF -> buffered; on ws_allowin=1, final_result=0xDEAD_BEEF; ms_allowin stays 0 until then.
- resetn=0 for 1 cycle mid-WAIT, then a stray data_ok -> ms_to_ws_valid stays 0, state IDLE, no spurious write.
- 4 back-to-back LW with data_ok every cycle -> 4 consecutive ms_to_ws_valid cycles, pcs in order, no gaps.
